// File: rtl/adc_spi_rx_master.sv
// SPI master that clocks one CPOL-0 frame out of an LTC2313-style ADC and returns the captured word.
// Optional ADC_SPI_CS_EN adds an active-low chip select that frames the transfer and qualifies MISO sampling.
module adc_spi_rx_master #(
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned FRAME_BITS = 14,
    parameter int unsigned CLK_DIV    = 3,
    parameter int unsigned SETUP_CLK  = 4,
    parameter int unsigned HOLD_CLK   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_fRST,
    input  logic                  i_spi_start,
    input  logic [DATA_WIDTH-1:0] i_spi_data,
    output logic [2:0]            o_spi_state,
    output logic [DATA_WIDTH-1:0] o_spi_data_rx,
    output logic                  o_spi_valid,
    output logic                  o_sck,
    output logic                  o_mosi,
`ifdef ADC_SPI_CS_EN
    output logic                  o_spi_cs_n,
`endif
    input  logic                  i_miso
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int unsigned WAIT_MAX = (SETUP_CLK > HOLD_CLK) ? SETUP_CLK : HOLD_CLK;
    localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    sck_q, sck_d;
    logic                    mosi_q, mosi_d;
    logic                    valid_q, valid_d;
    logic                    armed_q, armed_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic [DATA_WIDTH-1:0]   data_rx_q, data_rx_d;
`ifdef ADC_SPI_CS_EN
    logic                    cs_n_q, cs_n_d;
`endif

    logic start_ok;
    logic half_end;
    logic sck_rise;
    logic sck_fall;
    logic last_bit;
    logic wait_end;
    logic sample_en;

    // Edge and terminal-count decode shared by the FSM and the datapath
    always_comb begin
        start_ok = armed_q && i_spi_start;
        half_end = (div_q == DIV_W'(CLK_DIV - 1));
        sck_rise = (state_q == ST_SHIFT) && half_end && !sck_q;
        sck_fall = (state_q == ST_SHIFT) && half_end && sck_q;
        last_bit = (bit_q == BIT_W'(FRAME_BITS - 1));
        wait_end = (wait_q == '0);
`ifdef ADC_SPI_CS_EN
        sample_en = sck_rise && (32'(bit_q) < DATA_WIDTH) && !cs_n_q;
`else
        sample_en = sck_rise && (32'(bit_q) < DATA_WIDTH);
`endif
    end

    always_ff @(posedge i_clk or negedge i_fRST) begin
        if (!i_fRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_SETUP;
            ST_SETUP: if (wait_end) state_d = ST_SHIFT;
            ST_SHIFT: if (sck_fall && last_bit) state_d = ST_HOLD;
            ST_HOLD:  if (wait_end) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; everything visible is computed one cycle ahead
    always_comb begin
        div_d     = div_q;
        bit_d     = bit_q;
        wait_d    = wait_q;
        sck_d     = sck_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_rx_d = data_rx_q;
        valid_d   = 1'b0;
        mosi_d    = 1'b0;
        armed_d   = 1'b1;
`ifdef ADC_SPI_CS_EN
        cs_n_d    = 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    tx_d   = i_spi_data;
                    rx_d   = '0;
                    wait_d = WAIT_W'(SETUP_CLK - 1);
                    div_d  = '0;
                    bit_d  = '0;
                    sck_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                sck_d = 1'b0;
                div_d = '0;
                bit_d = '0;
                if (!wait_end) wait_d = wait_q - WAIT_W'(1);
            end
            ST_SHIFT: begin
                if (half_end) begin
                    div_d = '0;
                    sck_d = !sck_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                if (sample_en) rx_d = (rx_q << 1) | DATA_WIDTH'(i_miso);
                // MOSI moves on the falling edge; zeros shift in once the word is exhausted
                if (sck_fall) begin
                    tx_d = tx_q << 1;
                    if (last_bit) begin
                        wait_d = WAIT_W'(HOLD_CLK - 1);
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                sck_d = 1'b0;
                if (!wait_end) wait_d = wait_q - WAIT_W'(1);
            end
            default: ;
        endcase

        mosi_d  = tx_d[DATA_WIDTH-1];
        valid_d = (state_d == ST_DONE);
        if (valid_d) data_rx_d = rx_q;
`ifdef ADC_SPI_CS_EN
        cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
`endif
    end

    always_ff @(posedge i_clk or negedge i_fRST) begin
        if (!i_fRST) begin
            div_q     <= '0;
            bit_q     <= '0;
            wait_q    <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            valid_q   <= 1'b0;
            armed_q   <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_rx_q <= '0;
`ifdef ADC_SPI_CS_EN
            cs_n_q    <= 1'b1;
`endif
        end else begin
            div_q     <= div_d;
            bit_q     <= bit_d;
            wait_q    <= wait_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            valid_q   <= valid_d;
            armed_q   <= armed_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_rx_q <= data_rx_d;
`ifdef ADC_SPI_CS_EN
            cs_n_q    <= cs_n_d;
`endif
        end
    end

    assign o_spi_state   = state_q;
    assign o_spi_data_rx = data_rx_q;
    assign o_spi_valid   = valid_q;
    assign o_sck         = sck_q;
    assign o_mosi        = mosi_q;
`ifdef ADC_SPI_CS_EN
    assign o_spi_cs_n    = cs_n_q;
`endif

endmodule

// File: tb/tb_adc_spi_rx_master.sv
// Bench for adc_spi_rx_master: default 14-bit frame instance plus a FRAME_BITS=16 instance sharing one MISO model.
module tb_adc_spi_rx_master;

    localparam int SETUP = 4;
    localparam int DIV   = 3;
    localparam int HOLD  = 3;

    typedef struct {
        logic        sel;
        logic [13:0] tx;
        logic [15:0] miso16;
        logic [13:0] exp_rx;
        logic        extras;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic [13:0] data_a, data_b;
    logic [2:0]  state_a, state_b;
    logic [13:0] rx_a, rx_b;
    logic        valid_a, valid_b, sck_a, sck_b, mosi_a, mosi_b;
    logic        miso;
`ifdef ADC_SPI_CS_EN
    logic        cs_a, cs_b;
`endif

    adc_spi_rx_master dut_a (
        .i_clk(clk), .i_fRST(rst_n), .i_spi_start(start_a), .i_spi_data(data_a),
        .o_spi_state(state_a), .o_spi_data_rx(rx_a), .o_spi_valid(valid_a),
        .o_sck(sck_a), .o_mosi(mosi_a),
`ifdef ADC_SPI_CS_EN
        .o_spi_cs_n(cs_a),
`endif
        .i_miso(miso)
    );

    adc_spi_rx_master #(.FRAME_BITS(16)) dut_b (
        .i_clk(clk), .i_fRST(rst_n), .i_spi_start(start_b), .i_spi_data(data_b),
        .o_spi_state(state_b), .o_spi_data_rx(rx_b), .o_spi_valid(valid_b),
        .o_sck(sck_b), .o_mosi(mosi_b),
`ifdef ADC_SPI_CS_EN
        .o_spi_cs_n(cs_b),
`endif
        .i_miso(miso)
    );

    logic        use_b;
    logic [2:0]  m_state;
    logic [13:0] m_rx;
    logic        m_valid, m_sck, m_mosi, m_cs;

    always_comb begin
        m_state = use_b ? state_b : state_a;
        m_rx    = use_b ? rx_b : rx_a;
        m_valid = use_b ? valid_b : valid_a;
        m_sck   = use_b ? sck_b : sck_a;
        m_mosi  = use_b ? mosi_b : mosi_a;
`ifdef ADC_SPI_CS_EN
        m_cs    = use_b ? cs_b : cs_a;
`else
        m_cs    = 1'b1;
`endif
    end

    // ADC model: MSB-first pattern, advancing after each SCK falling edge
    logic [15:0] pat, mreg;
    logic        load, sck_prev;
    logic        noise = 1'b0;
    always @(posedge clk) begin
        sck_prev <= m_sck;
        noise    <= ~noise;
        if (load) mreg <= pat;
        else if (sck_prev && !m_sck) mreg <= mreg << 1;
    end
`ifdef ADC_SPI_CS_EN
    always_comb miso = m_cs ? noise : mreg[15];
`else
    always_comb miso = mreg[15];
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [13:0] exp_q[$];
    logic        mosi_q[$];
    logic [13:0] hold_rx[2];

    function automatic void chk(string nm, int cyc, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic int exp_state(int c, int f);
        if (c <= SETUP) return 1;
        if (c <= SETUP + 2 * DIV * f) return 2;
        if (c < 1 + SETUP + 2 * DIV * f + HOLD) return 3;
        return 4;
    endfunction

    function automatic int exp_sck(int c, int f);
        if (c < SETUP + 1 || c > SETUP + 2 * DIV * f) return 0;
        return (((c - SETUP - 1) % (2 * DIV)) >= DIV) ? 1 : 0;
    endfunction

    task automatic set_start(input logic v);
        start_a = use_b ? 1'b0 : v;
        start_b = use_b ? v : 1'b0;
    endtask

    // One frame with start at cycle 0; checks every cycle through DONE, or aborts via reset at abort_at
    task automatic run_frame(input vec_t v, input int abort_at);
        int          f, done, rises, sel;
        logic        prev_sck, prev_mosi, eb;
        logic [13:0] got;
        f    = v.sel ? 16 : 14;
        done = 1 + SETUP + 2 * DIV * f + HOLD;
        sel  = v.sel ? 1 : 0;
        @(posedge clk); #1;
        use_b = v.sel;
        if (v.sel) data_b = v.tx; else data_a = v.tx;
        set_start(1'b1);
        pat  = v.miso16;
        load = 1'b1;
        exp_q.push_back(v.exp_rx);
        for (int i = 0; i < f; i++) begin
            eb = (i < 14) ? v.tx[13 - i] : 1'b0;
            mosi_q.push_back(eb);
        end
        @(negedge clk);
        chk("idle_state", 0, int'(m_state), 0);
        chk("idle_valid", 0, int'(m_valid), 0);
        chk("idle_rx_hold", 0, int'(m_rx), int'(hold_rx[sel]));
        prev_sck  = m_sck;
        prev_mosi = m_mosi;
        rises     = 0;
        for (int c = 1; c <= done; c++) begin
            @(posedge clk); #1;
            load = 1'b0;
            set_start(v.extras && (c == 10 || c == 50 || c == done));
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_state", c, int'(state_a), 0);
                chk("abort_sck", c, int'(sck_a), 0);
                chk("abort_mosi", c, int'(mosi_a), 0);
                chk("abort_valid", c, int'(valid_a), 0);
                chk("abort_rx", c, int'(rx_a), 0);
`ifdef ADC_SPI_CS_EN
                chk("abort_cs_n", c, int'(cs_a), 1);
`endif
                return;
            end
            @(negedge clk);
            chk("state", c, int'(m_state), exp_state(c, f));
            chk("sck", c, int'(m_sck), exp_sck(c, f));
            chk("valid", c, int'(m_valid), int'(c == done));
`ifdef ADC_SPI_CS_EN
            chk("cs_n", c, int'(m_cs), int'(c == done));
`endif
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("valid_unexpected", c, 1, 0);
                end else begin
                    got = exp_q.pop_front();
                    chk("rx_data", c, int'(m_rx), int'(got));
                    hold_rx[sel] = got;
                end
            end else begin
                chk("rx_hold", c, int'(m_rx), int'(hold_rx[sel]));
            end
            if (m_sck && !prev_sck) begin
                rises++;
                chk("mosi_stable", c, int'(m_mosi), int'(prev_mosi));
                if (mosi_q.size() == 0) chk("mosi_extra_edge", c, 1, 0);
                else chk("mosi_bit", c, int'(m_mosi), int'(mosi_q.pop_front()));
            end
            prev_sck  = m_sck;
            prev_mosi = m_mosi;
        end
        chk("sck_rises", done, rises, f);
        chk("mosi_queue_left", done, mosi_q.size(), 0);
    endtask

    vec_t vecs[5];
    vec_t v_abort, v_after;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{sel: 1'b0, tx: 14'h3FFF, miso16: 16'hA970, exp_rx: 14'h2A5C, extras: 1'b1};
        vecs[1] = '{sel: 1'b0, tx: 14'h0001, miso16: 16'h5554, exp_rx: 14'h1555, extras: 1'b0};
        vecs[2] = '{sel: 1'b0, tx: 14'h0000, miso16: 16'h0000, exp_rx: 14'h0000, extras: 1'b0};
        vecs[3] = '{sel: 1'b0, tx: 14'h2A5C, miso16: 16'hFFFC, exp_rx: 14'h3FFF, extras: 1'b0};
        vecs[4] = '{sel: 1'b1, tx: 14'h1234, miso16: 16'hABCD, exp_rx: 14'h2AF3, extras: 1'b0};
        v_abort = '{sel: 1'b0, tx: 14'h3C3C, miso16: 16'h5A5A, exp_rx: 14'h1696, extras: 1'b0};
        v_after = '{sel: 1'b0, tx: 14'h15A5, miso16: 16'h30FC, exp_rx: 14'h0C3F, extras: 1'b0};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        data_a = '0; data_b = '0; pat = '0; load = 1'b0; use_b = 1'b0;
        hold_rx[0] = '0; hold_rx[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 0, int'(state_a), 0);
        chk("rst_rx", 0, int'(rx_a), 0);
        chk("rst_valid", 0, int'(valid_a), 0);
        chk("rst_sck", 0, int'(sck_a), 0);
        chk("rst_mosi", 0, int'(mosi_a), 0);
        chk("rst_state_b", 0, int'(state_b), 0);
`ifdef ADC_SPI_CS_EN
        chk("rst_cs_n", 0, int'(cs_a), 1);
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) run_frame(vecs[i], -1);

        // Reset in mid-SHIFT, with a stale start held across release
        run_frame(v_abort, 40);
        exp_q.delete();
        mosi_q.delete();
        hold_rx[0] = '0;
        hold_rx[1] = '0;
        start_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("post_rst_state", k, int'(state_a), 0);
            chk("post_rst_valid", k, int'(valid_a), 0);
            chk("post_rst_rx", k, int'(rx_a), 0);
        end
        run_frame(v_after, -1);

        chk("scoreboard_left", 0, exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
